// File: rtl/sctrl_reader_if.sv
// rtl/sctrl_reader_if.sv - output word stream of the sensor drain engine
interface sctrl_reader_if #(
  parameter int DATA_W = 32
);
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              out_ready;

  modport master (output out_valid, output out_data, output out_last, input out_ready);
  modport slave  (input out_valid, input out_data, input out_last, output out_ready);
endinterface

// File: rtl/sctrl_reader.sv
// rtl/sctrl_reader.sv - sensor controller drain engine; SCTRL_RD_CHECKSUM_BEAT_EN appends a checksum beat
module sctrl_reader #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                sctrl_interrupt,
  input  logic [DATA_W-1:0]   sctrl_out,
  output logic                sctrl_en,
  output logic                sctrl_clear,
  output logic [ADDR_W-1:0]   sctrl_addr,
  sctrl_reader_if.master      strm,
  output logic                batch_done,
  output logic [15:0]         batch_cnt,
  output logic [DATA_W-1:0]   checksum
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    DRAIN = 3'd2,
    CSUM  = 3'd3,
    CLEAR = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] sum_q;
  logic [15:0]       cnt_q;
  logic [DATA_W-1:0] csum_q;

  logic              valid_c;
  logic [DATA_W-1:0] data_c;
  logic              last_c;
  logic              en_c;
  logic              clear_c;
  logic              done_c;
  logic              at_last;

  assign at_last = (addr_q == LAST_ADDR);

  // State register; reset aborts any batch in progress without a clear pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and output decode; all control outputs follow the state so reset zeroes them at once
  always_comb begin
    state_d = state_q;
    valid_c = 1'b0;
    data_c  = '0;
    last_c  = 1'b0;
    en_c    = 1'b0;
    clear_c = 1'b0;
    done_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) state_d = FILL;
      end
      FILL: begin
        en_c = 1'b1;
        // a full buffer wins over a dropped enable so no batch is stranded
        if (sctrl_interrupt) state_d = DRAIN;
        else if (!enable)    state_d = IDLE;
      end
      DRAIN: begin
        valid_c = 1'b1;
        data_c  = sctrl_out;
`ifndef SCTRL_RD_CHECKSUM_BEAT_EN
        last_c  = at_last;
`endif
        if (strm.out_ready && at_last) begin
`ifdef SCTRL_RD_CHECKSUM_BEAT_EN
          state_d = CSUM;
`else
          state_d = CLEAR;
`endif
        end
      end
`ifdef SCTRL_RD_CHECKSUM_BEAT_EN
      CSUM: begin
        valid_c = 1'b1;
        data_c  = sum_q;
        last_c  = 1'b1;
        if (strm.out_ready) state_d = CLEAR;
      end
`endif
      CLEAR: begin
        clear_c = 1'b1;
        done_c  = 1'b1;
        state_d = enable ? FILL : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Address walk, running sum, and per-batch statistics
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
      sum_q  <= '0;
      cnt_q  <= '0;
      csum_q <= '0;
    end else begin
      case (state_q)
        FILL: begin
          addr_q <= '0;
          if (sctrl_interrupt) sum_q <= '0;
        end
        DRAIN: begin
          if (strm.out_ready) begin
            sum_q  <= sum_q + sctrl_out;
            addr_q <= at_last ? '0 : addr_q + 1'b1;
          end
        end
        CLEAR: begin
          csum_q <= sum_q;
          cnt_q  <= cnt_q + 16'd1;
        end
        default: ;
      endcase
    end
  end

  assign strm.out_valid = valid_c;
  assign strm.out_data  = data_c;
  assign strm.out_last  = last_c;
  assign sctrl_en       = en_c;
  assign sctrl_clear    = clear_c;
  assign batch_done     = done_c;
  assign sctrl_addr     = addr_q;
  assign batch_cnt      = cnt_q;
  assign checksum       = csum_q;

endmodule

// File: doc/sctrl_reader.md
Name: sctrl_reader

Overview:
- Core-side drain engine that sits directly downstream of the high-speed sensor controller.
- Arms the sensor controller with `sctrl_en`. When the controller signals its buffer is full (`sctrl_interrupt`), the block walks `sctrl_addr` from 0 to DEPTH-1 and streams each word out on a valid/ready interface.
- After the last word it pulses `sctrl_clear` for one cycle and re-arms for the next batch.
- Removes per-word software polling of the sensor buffer.

Parameters:
- DEPTH, 64, number of words per sensor batch; must equal the sensor controller buffer depth.
- ADDR_W, 6, width of `sctrl_addr`; DEPTH = 2**ADDR_W.
- DATA_W, 32, sensor word width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- enable  input  1  level; 1 = keep acquiring batches.
- sctrl_interrupt  input  1  sensor controller buffer full.
- sctrl_out  input  DATA_W  word at `sctrl_addr`; combinational, same cycle.
- sctrl_en  output  1  arms the sensor controller.
- sctrl_clear  output  1  one-cycle clear of the sensor controller.
- sctrl_addr  output  ADDR_W  read address into the sensor buffer.
- out_valid  output  1  stream word valid.
- out_data  output  DATA_W  stream word.
- out_last  output  1  final beat of the batch.
- out_ready  input  1  downstream accepts.
- batch_done  output  1  one-cycle pulse per completed batch.
- batch_cnt  output  16  completed batches; wraps 0xFFFF->0.
- checksum  output  DATA_W  sum of the last drained batch.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE.
  - `sctrl_en`, `sctrl_clear`, `out_valid`, `out_last`, `batch_done` = 0.
  - `sctrl_addr`, `out_data`, `batch_cnt`, `checksum` = 0.
- Reset asserted mid-batch aborts immediately. No clear pulse is issued; the sensor controller is reset by the same `rst`.
- State IDLE:
  - All control outputs 0.
  - `enable`=1 -> FILL on the next edge.
- State FILL:
  - `sctrl_en`=1, `sctrl_addr`=0.
  - `sctrl_interrupt`=1 -> DRAIN.
    - Registers `sctrl_en`=0.
    - Registers the running sum=0.
    - `interrupt` has priority over `enable`.
  - Otherwise, `enable`=0 -> IDLE. The partial batch is left in the sensor controller; no clear is issued.
- State DRAIN:
  - `sctrl_en`=0, `out_valid`=1.
  - `out_data` = `sctrl_out`, combinational from the registered `sctrl_addr`.
  - `out_last` = (`sctrl_addr`==DEPTH-1), except when the checksum feature is enabled; see Optional Feature.
  - Handshake (`out_valid` & `out_ready`):
    - sum += `out_data`, modulo 2**DATA_W (carry dropped).
    - `sctrl_addr` += 1.
  - Handshake at `sctrl_addr`==DEPTH-1:
    - `sctrl_addr` wraps to 0.
    - Next state is CLEAR (CSUM if the feature is enabled).
  - `out_data` and `out_last` hold stable while `out_valid`=1 and `out_ready`=0.
  - `enable` is ignored in DRAIN; the batch always completes.
- State CLEAR (exactly 1 cycle):
  - `sctrl_clear`=1, `batch_done`=1.
  - `checksum` <= sum.
  - `batch_cnt` += 1.
  - Next state: FILL if `enable`=1, else IDLE.
- Latency:
  - First beat is valid 1 cycle after `sctrl_interrupt` is sampled.
  - With `out_ready` held at 1: DEPTH beats in DEPTH cycles, then 1 clear cycle.
  - Minimum interrupt-to-rearm time: DEPTH+2 cycles.
- `out_valid` never depends combinationally on `out_ready`.

Optional Feature:
- Macro: `SCTRL_RD_CHECKSUM_BEAT_EN`.
- Defined:
  - DRAIN does not assert `out_last` on word DEPTH-1; it proceeds to state CSUM after that word's handshake.
  - CSUM: `out_valid`=1, `out_data` = final sum including word DEPTH-1, `out_last`=1.
  - Handshake in CSUM -> CLEAR.
  - Batch = DEPTH+1 beats.
- Undefined:
  - No CSUM state; batch = DEPTH beats, `out_last` on word DEPTH-1.
  - The `checksum` port is still updated in CLEAR in both builds.

Test Plan:
- Reset then `enable`=1, sensor model fills words i+1 (i=0..63), `out_ready`=1 -> 64 beats with data 1..64, `out_last` on beat 64 only.
  - Then `sctrl_clear` high exactly 1 cycle, `checksum`=2080, `batch_cnt`=1, `sctrl_en`=1 the following cycle.
- Same fill, `out_ready` toggling 1,0,0,1 pattern -> data sequence unchanged, `out_data` stable during stalls, exactly 64 handshakes.
- Fill 0xFFFFFFFF x64 -> `checksum`=0xFFFFFFC0 (wrap); with `SCTRL_RD_CHECKSUM_BEAT_EN`, beat 65 carries 0xFFFFFFC0 with `out_last`=1.
- `enable` dropped in FILL before interrupt -> IDLE next cycle, `sctrl_en`=0, no `sctrl_clear`, `batch_cnt` unchanged.
  - `enable` dropped at DRAIN beat 10 -> all 64 beats still sent, clear issued, then IDLE.
- `rst` pulsed asynchronously at DRAIN beat 30 -> outputs 0 immediately without a clock edge, state IDLE, `batch_cnt`=0.
- Run 3 back-to-back batches with `enable` held -> `batch_done` 3 single-cycle pulses, `batch_cnt`=3, `sctrl_addr` restarts at 0 each batch.
